pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 10: program counter width in bits.
REQ-002 SHALL have parameter RESET_ADDR, default 10'h200: PC value loaded on reset.
REQ-003 SHALL have parameter OFF_WIDTH, default 16: branch offset width in bits.
REQ-004 SHALL have parameter RAS_DEPTH, default 4: return-address stack (RAS) entries; must be a power of 2 and at least 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port stall, input, 1 bit: hold the PC; all other control inputs are ignored in that cycle.
REQ-008 SHALL have ports jump, call and ret, each input, 1 bit: unconditional jump, jump-and-push, and pop-and-return.
REQ-009 SHALL have ports branch (input, 1 bit) and cond (input, 2 bits): 00 BEQ, 01 BNE, 10 BLT, 11 BGE.
REQ-010 SHALL have ports zero and neg, each input, 1 bit: ALU flags.
REQ-011 SHALL have port offset, input, OFF_WIDTH bits: signed branch offset.
REQ-012 SHALL have port target, input, 26 bits: jump/call address.
REQ-013 SHALL have port pc, output, PC_WIDTH bits: current PC, registered.
REQ-014 SHALL have port redirect, output, 1 bit: registered; 1 when the last update was non-sequential.
REQ-015 SHALL have port ras_count, output, $clog2(RAS_DEPTH)+1 bits: number of valid RAS entries.
REQ-016 SHALL have ports ras_overflow and ras_underflow, each output, 1 bit: registered one-cycle pulses.

Function
REQ-017 SHALL evaluate branch taken as: BEQ when zero; BNE when !zero; BLT when neg; BGE when !neg.
REQ-018 SHALL apply update priority when stall=0: jump, then call, then ret, then taken branch, then pc+1.
REQ-019 SHALL load target[PC_WIDTH-1:0] into pc on jump.
REQ-020 SHALL, on call, load target[PC_WIDTH-1:0] into pc and push pc+1 onto the RAS.
REQ-021 SHALL, on ret with ras_count>0, load the RAS top into pc and pop.
REQ-022 SHALL, on ret with ras_count=0, load pc+1 and pulse ras_underflow.
REQ-023 SHALL compute the taken-branch target as pc plus sign-extended offset truncated to PC_WIDTH bits, wrapping modulo 2^PC_WIDTH.
REQ-024 SHALL wrap pc+1 from all-ones to 0.
REQ-025 SHALL, on call with the RAS full, overwrite the oldest entry (circular buffer), hold ras_count at RAS_DEPTH and pulse ras_overflow.
REQ-026 SHALL, when stall=1, hold pc and the RAS unchanged, drive redirect=0 and drive both RAS flags to 0.
REQ-027 SHALL set redirect=1 in the cycle after any jump, call, successful ret or taken branch, and 0 otherwise.
REQ-028 SHALL give every update a latency of one clock edge; there is no combinational path from any input to any output.

Reset
REQ-029 SHALL, on reset=1 at a rising edge, set pc=RESET_ADDR, redirect=0, ras_count=0, ras_overflow=0 and ras_underflow=0.
REQ-030 SHALL give reset priority over stall and over all control inputs, discarding any in-flight RAS contents.
REQ-031 SHALL leave RAS storage entries unreset; they are valid only per ras_count.

Configuration
REQ-032 SHALL, with macro PC_SEQUENCER_RAS_EN defined, implement the RAS exactly as in REQ-020 to REQ-025.
REQ-033 SHALL, with PC_SEQUENCER_RAS_EN undefined, omit RAS storage, treat call as jump, treat ret as pc+1 with redirect=0, and tie ras_count, ras_overflow and ras_underflow to 0.

Structure
REQ-034 SHALL place cond encodings (COND_BEQ, COND_BNE, COND_BLT, COND_BGE) and the default RESET_ADDR constant in shared package cpu_pkg.
REQ-035 SHALL implement the RAS as sub-module pc_ras (push, pop, top, count, full, empty).
REQ-036 SHALL keep next-PC selection combinational in pc_sequencer, with a single pc register.

Verification
REQ-037 SHALL cover reset: reset=1 for one edge -> pc=0x200, ras_count=0, redirect=0; six idle cycles -> pc=0x206.
REQ-038 SHALL cover branches: pc=0x210, branch=1, cond=01, zero=0, offset=-4 -> pc=0x20C, redirect=1; same with zero=1 -> pc=0x211, redirect=0.
REQ-039 SHALL cover call/return: call target=0x300 at pc=0x205 -> pc=0x300, ras_count=1; then ret -> pc=0x206, ras_count=0.
REQ-040 SHALL cover RAS limits: five calls with RAS_DEPTH=4 -> ras_overflow pulses once, ras_count=4; ret on empty RAS -> ras_underflow pulse, pc+1.
REQ-041 SHALL cover stall and priority: stall=1 with jump=1 -> pc unchanged, redirect=0; jump=1 with call=1 -> pc=target, ras_count unchanged.
REQ-042 SHALL cover wrap and mid-operation reset: pc=0x3FF idle -> pc=0x000; reset asserted together with call -> pc=0x200, ras_count=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: branch condition encodings, reset vector,
// and the branch-condition evaluator used by the PC sequencer.
package cpu_pkg;

  typedef enum logic [1:0] {
    COND_BEQ = 2'b00,
    COND_BNE = 2'b01,
    COND_BLT = 2'b10,
    COND_BGE = 2'b11
  } cond_e;

  localparam logic [9:0]  RESET_ADDR_DEFAULT = 10'h200;
  localparam int unsigned TARGET_WIDTH       = 26;

  // Branch-taken decision from the ALU flags
  function automatic logic branch_taken(input logic [1:0] cond,
                                        input logic       zero,
                                        input logic       neg);
    logic taken;
    taken = 1'b0;
    case (cond_e'(cond))
      COND_BEQ: taken = zero;
      COND_BNE: taken = ~zero;
      COND_BLT: taken = neg;
      COND_BGE: taken = ~neg;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer that overwrites its oldest entry when
// pushed while full. Storage is not reset; only count qualifies the contents.
module pc_ras #(
  parameter  int unsigned WIDTH = 10,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;

  // Write pointer and occupancy; count saturates at DEPTH on overwrite
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (!full) begin
        count <= count + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      wr_ptr <= wr_ptr - PTR_W'(1);
      count  <= count - CNT_W'(1);
    end
  end

  // Entry storage, intentionally without reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign top   = mem[wr_ptr - PTR_W'(1)];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: jump / call / return / conditional branch / pc+1
// with a single registered pc. The return-address stack is built only when
// PC_SEQUENCER_RAS_EN is defined; otherwise call behaves as jump, ret as pc+1.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter  int unsigned         PC_WIDTH   = 10,
  parameter  logic [PC_WIDTH-1:0] RESET_ADDR = PC_WIDTH'(RESET_ADDR_DEFAULT),
  parameter  int unsigned         OFF_WIDTH  = 16,
  parameter  int unsigned         RAS_DEPTH  = 4,
  localparam int unsigned         CNT_W      = $clog2(RAS_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    jump,
  input  logic                    call,
  input  logic                    ret,
  input  logic                    branch,
  input  logic [1:0]              cond,
  input  logic                    zero,
  input  logic                    neg,
  input  logic [OFF_WIDTH-1:0]    offset,
  input  logic [TARGET_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0]     pc,
  output logic                    redirect,
  output logic [CNT_W-1:0]        ras_count,
  output logic                    ras_overflow,
  output logic                    ras_underflow
);

  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] pc_branch;
  logic [PC_WIDTH-1:0] pc_next;
  logic                redirect_next;
  logic                taken;
  logic                unused_target_hi;

  // Upper target bits beyond the PC width are don't-care
  assign unused_target_hi = ^target[TARGET_WIDTH-1:PC_WIDTH];

  assign pc_seq    = pc + PC_WIDTH'(1);
  // Offset is sign-extended (or truncated) to PC width; the sum wraps
  assign pc_branch = pc + PC_WIDTH'($signed(offset));
  assign taken     = branch & branch_taken(cond, zero, neg);

`ifdef PC_SEQUENCER_RAS_EN
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_full;
  logic                ras_empty;
  logic                ras_push;
  logic                ras_pop;
  logic                ovf_next;
  logic                unf_next;

  pc_ras #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // Next-PC selection by priority: jump, call, ret, taken branch, pc+1
  always_comb begin
    pc_next       = pc_seq;
    redirect_next = 1'b0;
    ras_push      = 1'b0;
    ras_pop       = 1'b0;
    ovf_next      = 1'b0;
    unf_next      = 1'b0;
    if (stall) begin
      pc_next = pc;
    end else if (jump) begin
      pc_next       = target[PC_WIDTH-1:0];
      redirect_next = 1'b1;
    end else if (call) begin
      pc_next       = target[PC_WIDTH-1:0];
      redirect_next = 1'b1;
      ras_push      = 1'b1;
      ovf_next      = ras_full;
    end else if (ret) begin
      if (!ras_empty) begin
        pc_next       = ras_top;
        redirect_next = 1'b1;
        ras_pop       = 1'b1;
      end else begin
        unf_next = 1'b1;
      end
    end else if (taken) begin
      pc_next       = pc_branch;
      redirect_next = 1'b1;
    end
  end

  // One-cycle RAS status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      ras_overflow  <= ovf_next;
      ras_underflow <= unf_next;
    end
  end
`else
  assign ras_count     = '0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;

  // Next-PC selection without a RAS: call acts as jump, ret as pc+1
  always_comb begin
    pc_next       = pc_seq;
    redirect_next = 1'b0;
    if (stall) begin
      pc_next = pc;
    end else if (jump || call) begin
      pc_next       = target[PC_WIDTH-1:0];
      redirect_next = 1'b1;
    end else if (ret) begin
      pc_next = pc_seq;
    end else if (taken) begin
      pc_next       = pc_branch;
      redirect_next = 1'b1;
    end
  end
`endif

  // The single PC register and redirect flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_ADDR;
      redirect <= 1'b0;
    end else begin
      pc       <= pc_next;
      redirect <= redirect_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table followed by a random phase
// checked against a behavioural model; honours PC_SEQUENCER_RAS_EN.
`timescale 1ns/1ps
module tb_pc_sequencer;
  import cpu_pkg::*;

  localparam int unsigned PW = 10;
  localparam int unsigned OW = 16;
  localparam int unsigned RD = 4;
  localparam int unsigned CW = 3;
`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        jump;
    logic        call;
    logic        ret;
    logic        branch;
    logic [1:0]  cond;
    logic        zero;
    logic        neg;
    logic [15:0] offset;
    logic [25:0] target;
  } in_t;

  typedef struct packed {
    logic [9:0] pc;
    logic       redir;
    logic [2:0] cnt;
    logic       ovf;
    logic       unf;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0, stall = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic          branch = 1'b0, zero = 1'b0, neg = 1'b0;
  logic [1:0]    cond = 2'b00;
  logic [OW-1:0] offset = '0;
  logic [25:0]   target = '0;
  logic [PW-1:0] pc;
  logic          redirect;
  logic [CW-1:0] ras_count;
  logic          ras_overflow, ras_underflow;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  vec_t tbl[$];

  logic [9:0] m_pc;
  logic [9:0] m_ras[$];

  pc_sequencer #(
    .PC_WIDTH   (PW),
    .RESET_ADDR (10'h200),
    .OFF_WIDTH  (OW),
    .RAS_DEPTH  (RD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .jump          (jump),
    .call          (call),
    .ret           (ret),
    .branch        (branch),
    .cond          (cond),
    .zero          (zero),
    .neg           (neg),
    .offset        (offset),
    .target        (target),
    .pc            (pc),
    .redirect      (redirect),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  function automatic in_t idle();
    in_t x;
    x = '0;
    return x;
  endfunction

  function automatic in_t rst_i();
    in_t x;
    x = '0;
    x.rst = 1'b1;
    return x;
  endfunction

  function automatic in_t jmp(input logic [25:0] t);
    in_t x;
    x = '0;
    x.jump = 1'b1;
    x.target = t;
    return x;
  endfunction

  function automatic in_t cal(input logic [25:0] t);
    in_t x;
    x = '0;
    x.call = 1'b1;
    x.target = t;
    return x;
  endfunction

  function automatic in_t rt();
    in_t x;
    x = '0;
    x.ret = 1'b1;
    return x;
  endfunction

  function automatic in_t br(input logic [1:0] c, input logic z, input logic n,
                             input logic [15:0] o);
    in_t x;
    x = '0;
    x.branch = 1'b1;
    x.cond = c;
    x.zero = z;
    x.neg = n;
    x.offset = o;
    return x;
  endfunction

  function automatic in_t stl(input in_t x);
    in_t y;
    y = x;
    y.stall = 1'b1;
    return y;
  endfunction

  function automatic exp_t ex(input logic [9:0] p, input logic r, input logic [2:0] c,
                              input logic o, input logic u);
    exp_t e;
    e.pc = p;
    e.redir = r;
    e.cnt = c;
    e.ovf = o;
    e.unf = u;
    return e;
  endfunction

  // Behavioural reference: RAS kept as a queue, newest entry at the back
  task automatic model(input in_t x, output exp_t e);
    logic tk;
    e = '0;
    tk = 1'b0;
    case (x.cond)
      2'b00: tk = x.zero;
      2'b01: tk = !x.zero;
      2'b10: tk = x.neg;
      default: tk = !x.neg;
    endcase
    if (x.rst) begin
      m_pc = 10'h200;
      m_ras.delete();
    end else if (x.stall) begin
      m_pc = m_pc;
    end else if (x.jump) begin
      m_pc = x.target[9:0];
      e.redir = 1'b1;
    end else if (x.call) begin
      if (RAS) begin
        if (m_ras.size() == RD) begin
          void'(m_ras.pop_front());
          e.ovf = 1'b1;
        end
        m_ras.push_back(m_pc + 10'd1);
      end
      m_pc = x.target[9:0];
      e.redir = 1'b1;
    end else if (x.ret) begin
      if (RAS && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
        e.redir = 1'b1;
      end else begin
        e.unf = RAS;
        m_pc = m_pc + 10'd1;
      end
    end else if (x.branch && tk) begin
      m_pc = m_pc + x.offset[9:0];
      e.redir = 1'b1;
    end else begin
      m_pc = m_pc + 10'd1;
    end
    e.pc = m_pc;
    e.cnt = 3'(m_ras.size());
  endtask

  task automatic check(input string tag, input int idx);
    exp_t e;
    exp_t a;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s[%0d]: scoreboard empty, no expected value queued", tag, idx);
    end else begin
      e = exp_q.pop_front();
      a = {pc, redirect, ras_count, ras_overflow, ras_underflow};
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s[%0d]: got pc=%h redirect=%b ras_count=%0d ovf=%b unf=%b; expected pc=%h redirect=%b ras_count=%0d ovf=%b unf=%b",
                 tag, idx, a.pc, a.redir, a.cnt, a.ovf, a.unf, e.pc, e.redir, e.cnt, e.ovf, e.unf);
      end
    end
  endtask

  task automatic run_vec(input in_t x, input exp_t e, input string tag, input int idx);
    @(negedge clk);
    reset  = x.rst;
    stall  = x.stall;
    jump   = x.jump;
    call   = x.call;
    ret    = x.ret;
    branch = x.branch;
    cond   = x.cond;
    zero   = x.zero;
    neg    = x.neg;
    offset = x.offset;
    target = x.target;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag, idx);
  endtask

  initial begin
    in_t  x;
    exp_t e;

    // Reset, then six idle cycles
    tbl.push_back('{rst_i(), ex(10'h200, 0, 0, 0, 0)});
    for (int i = 1; i <= 6; i++) tbl.push_back('{idle(), ex(10'h200 + 10'(i), 0, 0, 0, 0)});
    // Call from 0x205 and return
    tbl.push_back('{rst_i(), ex(10'h200, 0, 0, 0, 0)});
    for (int i = 1; i <= 5; i++) tbl.push_back('{idle(), ex(10'h200 + 10'(i), 0, 0, 0, 0)});
    tbl.push_back('{cal(26'h300), RAS ? ex(10'h300, 1, 1, 0, 0) : ex(10'h300, 1, 0, 0, 0)});
    tbl.push_back('{rt(),         RAS ? ex(10'h206, 1, 0, 0, 0) : ex(10'h301, 0, 0, 0, 0)});
    // Branches (target upper bits ignored on jump)
    tbl.push_back('{jmp(26'h3FFFE10),                ex(10'h210, 1, 0, 0, 0)});
    tbl.push_back('{br(COND_BNE, 0, 0, 16'hFFFC),   ex(10'h20C, 1, 0, 0, 0)});
    tbl.push_back('{jmp(26'h210),                    ex(10'h210, 1, 0, 0, 0)});
    tbl.push_back('{br(COND_BNE, 1, 0, 16'hFFFC),   ex(10'h211, 0, 0, 0, 0)});
    tbl.push_back('{br(COND_BEQ, 1, 0, 16'h0008),   ex(10'h219, 1, 0, 0, 0)});
    tbl.push_back('{br(COND_BLT, 0, 1, 16'h0100),   ex(10'h319, 1, 0, 0, 0)});
    tbl.push_back('{br(COND_BGE, 0, 1, 16'h0100),   ex(10'h31A, 0, 0, 0, 0)});
    tbl.push_back('{br(COND_BGE, 0, 0, 16'h00E6),   ex(10'h000, 1, 0, 0, 0)});
    tbl.push_back('{br(COND_BLT, 0, 0, 16'h0005),   ex(10'h001, 0, 0, 0, 0)});
    x = br(COND_BEQ, 1, 0, 16'h0010);
    x.branch = 1'b0;
    tbl.push_back('{x,                               ex(10'h002, 0, 0, 0, 0)});
    // Five calls into a four-deep RAS, then drain and underflow
    tbl.push_back('{cal(26'h100), ex(10'h100, 1, RAS ? 3'd1 : 3'd0, 0, 0)});
    tbl.push_back('{cal(26'h110), ex(10'h110, 1, RAS ? 3'd2 : 3'd0, 0, 0)});
    tbl.push_back('{cal(26'h120), ex(10'h120, 1, RAS ? 3'd3 : 3'd0, 0, 0)});
    tbl.push_back('{cal(26'h130), ex(10'h130, 1, RAS ? 3'd4 : 3'd0, 0, 0)});
    tbl.push_back('{cal(26'h140), ex(10'h140, 1, RAS ? 3'd4 : 3'd0, RAS, 0)});
    tbl.push_back('{idle(),       ex(10'h141, 0, RAS ? 3'd4 : 3'd0, 0, 0)});
    tbl.push_back('{rt(), RAS ? ex(10'h131, 1, 3, 0, 0) : ex(10'h142, 0, 0, 0, 0)});
    tbl.push_back('{rt(), RAS ? ex(10'h121, 1, 2, 0, 0) : ex(10'h143, 0, 0, 0, 0)});
    tbl.push_back('{rt(), RAS ? ex(10'h111, 1, 1, 0, 0) : ex(10'h144, 0, 0, 0, 0)});
    tbl.push_back('{rt(), RAS ? ex(10'h101, 1, 0, 0, 0) : ex(10'h145, 0, 0, 0, 0)});
    tbl.push_back('{rt(), RAS ? ex(10'h102, 0, 0, 0, 1) : ex(10'h146, 0, 0, 0, 0)});
    tbl.push_back('{stl(rt()), RAS ? ex(10'h102, 0, 0, 0, 0) : ex(10'h146, 0, 0, 0, 0)});
    // Stall and priority
    tbl.push_back('{cal(26'h2AA),      ex(10'h2AA, 1, RAS ? 3'd1 : 3'd0, 0, 0)});
    tbl.push_back('{stl(jmp(26'h050)), ex(10'h2AA, 0, RAS ? 3'd1 : 3'd0, 0, 0)});
    tbl.push_back('{stl(cal(26'h055)), ex(10'h2AA, 0, RAS ? 3'd1 : 3'd0, 0, 0)});
    x = jmp(26'h077);
    x.call = 1'b1;
    tbl.push_back('{x,                 ex(10'h077, 1, RAS ? 3'd1 : 3'd0, 0, 0)});
    // Wrap and reset during call
    tbl.push_back('{jmp(26'h3FF),      ex(10'h3FF, 1, RAS ? 3'd1 : 3'd0, 0, 0)});
    tbl.push_back('{idle(),            ex(10'h000, 0, RAS ? 3'd1 : 3'd0, 0, 0)});
    x = cal(26'h123);
    x.rst = 1'b1;
    tbl.push_back('{x,                 ex(10'h200, 0, 0, 0, 0)});
    tbl.push_back('{rt(),              ex(10'h201, 0, 0, 0, RAS)});

    foreach (tbl[i]) run_vec(tbl[i].i, tbl[i].e, "tbl", i);

    // Random phase against the reference model
    model(rst_i(), e);
    run_vec(rst_i(), e, "rnd_rst", 0);
    for (int i = 0; i < 400; i++) begin
      x        = '0;
      x.rst    = ($urandom_range(0, 31) == 0);
      x.stall  = ($urandom_range(0, 7) == 0);
      x.jump   = ($urandom_range(0, 7) == 0);
      x.call   = ($urandom_range(0, 4) == 0);
      x.ret    = ($urandom_range(0, 4) == 0);
      x.branch = $urandom_range(0, 1) == 1;
      x.cond   = 2'($urandom_range(0, 3));
      x.zero   = $urandom_range(0, 1) == 1;
      x.neg    = $urandom_range(0, 1) == 1;
      x.offset = 16'($urandom_range(0, 64)) - 16'd32;
      x.target = 26'($urandom);
      model(x, e);
      run_vec(x, e, "rnd", i);
    end

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
